// File: rtl/bitvec_id_streamer.sv
// bitvec_id_streamer
//
// Buffers selected-resource bitmaps in a small FIFO and streams out the
// index of every set bit, lowest index first, one id per beat, with a
// valid/ready handshake. At most MAX_IDS ids are emitted per vector; when
// more bits were set, the final beat flags id_trunc. An all-zero vector
// produces a single id_empty beat so the consumer still sees one id_last
// per vector.
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   vec_in       : bitmap to enqueue
//   vec_valid_in : vec_in valid this cycle (no backpressure upstream)
//   id_out       : resource index of the current beat
//   id_valid     : beat valid
//   id_ready     : consumer accepts the beat
//   id_last      : final beat of the current vector
//   id_empty     : vector had no set bits (id_out = 0)
//   id_trunc     : final beat left set bits unemitted
//   id_count     : ids emitted for the vector, valid with id_last
//   overflow     : sticky, a vector was dropped because the FIFO was full
//   fifo_level   : current FIFO occupancy
module bitvec_id_streamer #(
  parameter int BIT_VEC_SIZE     = 128,
  parameter int BIT_VEC_SIZE_LOG = 7,
  parameter int FIFO_DEPTH       = 4,
  parameter int MAX_IDS          = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [BIT_VEC_SIZE-1:0]           vec_in,
  input  logic                              vec_valid_in,
  output logic [BIT_VEC_SIZE_LOG-1:0]       id_out,
  output logic                              id_valid,
  input  logic                              id_ready,
  output logic                              id_last,
  output logic                              id_empty,
  output logic                              id_trunc,
  output logic [$clog2(MAX_IDS):0]          id_count,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(MAX_IDS) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [BIT_VEC_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [BIT_VEC_SIZE-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [BIT_VEC_SIZE-1:0] cur_vec_q, cur_vec_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    overflow_q, overflow_d;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic [BIT_VEC_SIZE-1:0]     cur_minus_one;
  logic                        multi_bit;
  logic                        at_cap;
  logic                        is_last;
  logic [BIT_VEC_SIZE_LOG-1:0] lsb_idx;
  logic                        push;
  logic                        pop;

  assign fifo_full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty    = (level_q == '0);
  // x & (x-1) clears the lowest set bit; anything left means two or more bits
  assign cur_minus_one = cur_vec_q - BIT_VEC_SIZE'(1);
  assign multi_bit     = |(cur_vec_q & cur_minus_one);
  assign at_cap        = (cnt_q == CNT_W'(MAX_IDS - 1));
  assign is_last       = !multi_bit || at_cap;
  assign overflow      = overflow_q;
  assign fifo_level    = level_q;

  // Priority encoder: scanning downward leaves the lowest set index
  always_comb begin
    lsb_idx = '0;
    for (int i = BIT_VEC_SIZE - 1; i >= 0; i--) begin
      if (cur_vec_q[i]) begin
        lsb_idx = BIT_VEC_SIZE_LOG'(i);
      end
    end
  end

  // Next-state, FIFO bookkeeping and beat outputs
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    cur_vec_d  = cur_vec_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    pop        = 1'b0;
    id_out     = '0;
    id_valid   = 1'b0;
    id_last    = 1'b0;
    id_empty   = 1'b0;
    id_trunc   = 1'b0;
    id_count   = '0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          cur_vec_d = mem_q[rd_ptr_q];
          cnt_d     = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        id_valid = 1'b1;
        id_empty = (cur_vec_q == '0);
        id_out   = lsb_idx;
        id_last  = is_last;
        if (is_last) begin
          id_trunc = at_cap && multi_bit;
          id_count = id_empty ? '0 : cnt_q + CNT_W'(1);
        end
        if (id_ready) begin
          if (is_last) begin
            // Chain straight into the next vector so there is no bubble
            if (!fifo_empty) begin
              pop       = 1'b1;
              cur_vec_d = mem_q[rd_ptr_q];
              cnt_d     = '0;
            end else begin
              cur_vec_d = '0;
              cnt_d     = '0;
              state_d   = IDLE;
            end
          end else begin
            cur_vec_d = cur_vec_q & cur_minus_one;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A full FIFO still accepts a vector when a slot frees up this cycle
    push = vec_valid_in && (!fifo_full || pop);
    if (vec_valid_in && !push) begin
      overflow_d = 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q] = vec_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cur_vec_q  <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cur_vec_q  <= cur_vec_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_bitvec_id_streamer.sv
// tb_bitvec_id_streamer
//
// Self-checking bench for bitvec_id_streamer at default parameters.
// Expected beats come from a bit-scanning model and sit in a queue until
// the DUT hands the matching beat over; a table of vectors adds per-vector
// totals, and hand-written sequences cover latency, back-to-back vectors,
// overflow and reset in the middle of a vector.
module tb_bitvec_id_streamer;

  logic         clk;
  logic         rst;
  logic [127:0] vec_in;
  logic         vec_valid_in;
  logic [6:0]   id_out;
  logic         id_valid;
  logic         id_ready;
  logic         id_last;
  logic         id_empty;
  logic         id_trunc;
  logic [4:0]   id_count;
  logic         overflow;
  logic [2:0]   fifo_level;

  bitvec_id_streamer #(
    .BIT_VEC_SIZE    (128),
    .BIT_VEC_SIZE_LOG(7),
    .FIFO_DEPTH      (4),
    .MAX_IDS         (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vec_in      (vec_in),
    .vec_valid_in(vec_valid_in),
    .id_out      (id_out),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_last     (id_last),
    .id_empty    (id_empty),
    .id_trunc    (id_trunc),
    .id_count    (id_count),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  typedef struct {
    logic [6:0] id;
    logic       last;
    logic       empty;
    logic       trunc;
    logic [4:0] count;
  } beat_t;

  typedef struct {
    logic [127:0] vec;
    int           exp_beats;
    logic [4:0]   exp_count;
    logic         exp_trunc;
    logic         rnd_ready;
  } vec_case_t;

  beat_t     exp_q[$];
  beat_t     mon_e;
  vec_case_t tbl[8];

  int         compared;
  int         mismatched;
  int         cyc;
  bit         mon_en;
  int         beats_seen;
  int         last_beat_cyc;
  int         prev_beat_cyc;
  logic [4:0] last_count;
  logic       last_trunc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Watchdog so a stuck handshake still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: walk the bitmap upward, emit up to 16 ids
  task automatic pushExpected(input logic [127:0] v);
    int    n;
    int    emitted;
    beat_t b;
    n = 0;
    emitted = 0;
    for (int i = 0; i < 128; i++) if (v[i]) n++;
    if (n == 0) begin
      b.id = 7'd0; b.last = 1'b1; b.empty = 1'b1; b.trunc = 1'b0; b.count = 5'd0;
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < 128; i++) begin
        if (v[i] && emitted < 16) begin
          emitted++;
          b.id    = 7'(i);
          b.last  = (emitted == 16) || (emitted == n);
          b.empty = 1'b0;
          b.trunc = (emitted == 16) && (n > 16);
          b.count = b.last ? 5'(emitted) : 5'd0;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [127:0] v, input bit expect_it);
    vec_in       = v;
    vec_valid_in = 1'b1;
    if (expect_it) pushExpected(v);
    tick();
    vec_valid_in = 1'b0;
    vec_in       = '0;
  endtask

  task automatic drain(input bit rnd, input string name);
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
      id_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    id_ready = 1'b1;
    tick();
    tick();
    checkOutput({name, " drained"}, exp_q.size(), 0);
  endtask

  // Scoreboard side: compare each accepted beat with the model
  always @(negedge clk) begin
    if (mon_en && !rst && id_valid && id_ready) begin
      beats_seen++;
      prev_beat_cyc = last_beat_cyc;
      last_beat_cyc = cyc;
      if (id_last) begin
        last_count = id_count;
        last_trunc = id_trunc;
      end
      if (exp_q.size() == 0) begin
        checkOutput("unexpected beat", {25'd0, id_out}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("beat",
          {17'd0, id_out, id_last, id_empty, id_trunc, id_last ? id_count : 5'd0},
          {17'd0, mon_e.id, mon_e.last, mon_e.empty, mon_e.trunc, mon_e.count});
      end
    end
  end

  initial begin
    logic [127:0] v;
    compared      = 0;
    mismatched    = 0;
    beats_seen    = 0;
    last_beat_cyc = 0;
    prev_beat_cyc = 0;
    last_count    = 5'h1F;
    last_trunc    = 1'b0;
    mon_en        = 1'b0;
    rst           = 1'b1;
    vec_in        = '0;
    vec_valid_in  = 1'b0;
    id_ready      = 1'b1;

    v = '0; v[3] = 1'b1; v[64] = 1'b1; v[127] = 1'b1;
    tbl[0] = '{vec: v, exp_beats: 3, exp_count: 5'd3, exp_trunc: 1'b0, rnd_ready: 1'b0};
    tbl[1] = '{vec: '0, exp_beats: 1, exp_count: 5'd0, exp_trunc: 1'b0, rnd_ready: 1'b0};
    tbl[2] = '{vec: '1, exp_beats: 16, exp_count: 5'd16, exp_trunc: 1'b1, rnd_ready: 1'b1};
    tbl[3] = '{vec: 128'h1FFFF, exp_beats: 16, exp_count: 5'd16, exp_trunc: 1'b1, rnd_ready: 1'b0};
    tbl[4] = '{vec: (128'hFFFF << 100), exp_beats: 16, exp_count: 5'd16, exp_trunc: 1'b0, rnd_ready: 1'b0};
    tbl[5] = '{vec: 128'd1, exp_beats: 1, exp_count: 5'd1, exp_trunc: 1'b0, rnd_ready: 1'b0};
    tbl[6] = '{vec: (128'd1 << 127), exp_beats: 1, exp_count: 5'd1, exp_trunc: 1'b0, rnd_ready: 1'b0};
    tbl[7] = '{vec: 128'hAAAA, exp_beats: 8, exp_count: 5'd8, exp_trunc: 1'b0, rnd_ready: 1'b1};

    repeat (3) tick();
    checkOutput("reset outputs",
      {12'd0, id_out, id_valid, id_last, id_empty, id_trunc, id_count, overflow, fifo_level}, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    // First beat appears two edges after the vector is sampled
    beats_seen   = 0;
    vec_in       = tbl[0].vec;
    vec_valid_in = 1'b1;
    pushExpected(tbl[0].vec);
    tick();
    vec_valid_in = 1'b0;
    vec_in       = '0;
    checkOutput("latency after e0 valid", {31'd0, id_valid}, 32'd0);
    tick();
    checkOutput("latency after e1 valid", {31'd0, id_valid}, 32'd1);
    checkOutput("latency first id", {25'd0, id_out}, 32'd3);
    drain(1'b0, "latency");
    checkOutput("latency beats", beats_seen, 3);
    checkOutput("latency count", {27'd0, last_count}, 32'd3);

    // Table of vectors, one at a time
    for (int i = 0; i < 8; i++) begin
      beats_seen = 0;
      last_count = 5'h1F;
      last_trunc = 1'bx;
      applyStimulus(tbl[i].vec, 1'b1);
      drain(tbl[i].rnd_ready, $sformatf("tbl%0d", i));
      checkOutput($sformatf("tbl%0d beats", i), beats_seen, tbl[i].exp_beats);
      checkOutput($sformatf("tbl%0d count", i), {27'd0, last_count}, {27'd0, tbl[i].exp_count});
      checkOutput($sformatf("tbl%0d trunc", i), {31'd0, last_trunc}, {31'd0, tbl[i].exp_trunc});
    end

    // Back-to-back single-bit vectors stream with no gap
    beats_seen = 0;
    applyStimulus(128'd1 << 5, 1'b1);
    applyStimulus(128'd1 << 9, 1'b1);
    checkOutput("b2b level push+pop", {29'd0, fifo_level}, 32'd1);
    drain(1'b0, "b2b");
    checkOutput("b2b beats", beats_seen, 2);
    checkOutput("b2b gap", last_beat_cyc - prev_beat_cyc, 1);

    // Six vectors while stalled: four buffered, one in flight, one dropped
    beats_seen = 0;
    id_ready   = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(128'd1 << (10 + k), k < 5);
    end
    checkOutput("ovf level", {29'd0, fifo_level}, 32'd4);
    checkOutput("ovf flag", {31'd0, overflow}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("stall hold",
        {22'd0, id_valid, id_last, id_empty, id_out},
        {22'd0, 1'b1, 1'b1, 1'b0, 7'd10});
      tick();
    end
    drain(1'b0, "ovf");
    checkOutput("ovf beats", beats_seen, 5);
    checkOutput("ovf level drained", {29'd0, fifo_level}, 32'd0);
    checkOutput("ovf flag sticky", {31'd0, overflow}, 32'd1);

    // Reset during the second beat of {1,2,3}
    mon_en   = 1'b0;
    id_ready = 1'b1;
    exp_q.delete();
    applyStimulus(128'h0E, 1'b0);
    tick();
    checkOutput("mid beat1 id", {25'd0, id_out}, 32'd1);
    tick();
    checkOutput("mid beat2 id", {25'd0, id_out}, 32'd2);
    rst = 1'b1;
    tick();
    checkOutput("mid reset outputs",
      {12'd0, id_out, id_valid, id_last, id_empty, id_trunc, id_count, overflow, fifo_level}, 32'd0);
    rst        = 1'b0;
    mon_en     = 1'b1;
    beats_seen = 0;
    last_count = 5'h1F;
    applyStimulus(128'd1 << 7, 1'b1);
    drain(1'b0, "post reset");
    checkOutput("post reset beats", beats_seen, 1);
    checkOutput("post reset count", {27'd0, last_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bitvec_id_streamer.md
BITVEC_ID_STREAMER -- requirements
Module: bitvec_id_streamer

Interface
REQ-001 SHALL have parameter BIT_VEC_SIZE, default 128: width of the cell output bit vector.
REQ-002 SHALL have parameter BIT_VEC_SIZE_LOG, default 7: width of one resource id.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: number of vectors buffered; power of two, at least 2.
REQ-004 SHALL have parameter MAX_IDS, default 16: maximum ids emitted per vector, matching the cell K.
REQ-005 SHALL have port clk, input, 1: clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-007 SHALL have port vec_in, input, BIT_VEC_SIZE: selected-resource bitmap from the bfpu output.
REQ-008 SHALL have port vec_valid_in, input, 1: vec_in is valid this cycle; there is no upstream backpressure.
REQ-009 SHALL have port id_out, output, BIT_VEC_SIZE_LOG: resource index of the current beat.
REQ-010 SHALL have port id_valid, output, 1: beat valid.
REQ-011 SHALL have port id_ready, input, 1: consumer accepts the beat.
REQ-012 SHALL have port id_last, output, 1: final beat of the current vector.
REQ-013 SHALL have port id_empty, output, 1: the vector had no set bits; id_out=0 on this beat.
REQ-014 SHALL have port id_trunc, output, 1: the last beat left set bits unemitted.
REQ-015 SHALL have port id_count, output, clog2(MAX_IDS)+1: ids emitted for the vector; valid when id_last=1.
REQ-016 SHALL have port overflow, output, 1: sticky flag, set when a vector is dropped.
REQ-017 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-018 SHALL push vec_in into the FIFO at a rising edge where vec_valid_in=1 and the FIFO is not full, or is full with a pop occurring in the same cycle.
REQ-019 SHALL drop the vector when vec_valid_in=1, the FIFO is full and no pop occurs, and SHALL set overflow=1 until reset.
REQ-020 SHALL implement an FSM with states IDLE and SCAN, and a working register cur_vec with a beat counter cnt.
REQ-021 In IDLE with the FIFO non-empty, SHALL pop the head into cur_vec, clear cnt to 0 and enter SCAN at the next edge; id_valid=0 in IDLE.
REQ-022 A vector sampled at edge e0 SHALL present id_valid=1 after edge e1 when the FSM is idle and the FIFO is empty (2-cycle latency).
REQ-023 In SCAN, SHALL drive id_valid=1 and id_out = index of the least-significant set bit of cur_vec.
REQ-024 In SCAN, id_last SHALL be 1 when cur_vec has at most one set bit or cnt=MAX_IDS-1.
REQ-025 In SCAN with cur_vec=0, SHALL drive id_empty=1, id_last=1, id_out=0 and id_count=0.
REQ-026 On a handshake (id_valid and id_ready), SHALL clear the emitted bit in cur_vec and increment cnt.
REQ-027 On the last beat, id_count SHALL equal cnt+1 for a non-empty vector.
REQ-028 On the last beat, id_trunc SHALL be 1 if cnt=MAX_IDS-1 and cur_vec has more than one set bit.
REQ-029 On a handshake with id_last=1 and the FIFO non-empty, SHALL pop the next vector into cur_vec, reset cnt and stay in SCAN with no bubble cycle.
REQ-030 On a handshake with id_last=1 and the FIFO empty, SHALL return to IDLE.
REQ-031 While id_ready=0, all id_* outputs SHALL hold stable.
REQ-032 fifo_level SHALL reflect pushes and pops after each edge; a simultaneous push and pop SHALL leave it unchanged.
REQ-033 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-034 While rst=1 at an edge, SHALL clear the FIFO, cur_vec, cnt, overflow and fifo_level to 0 and enter IDLE.
REQ-035 After reset, all outputs SHALL be 0.
REQ-036 Reset asserted mid-vector SHALL abandon the remaining beats without emitting id_last.

Verification
REQ-037 Single vector, bits 3, 64 and 127 set, id_ready=1 -> ids 3, 64, 127 on consecutive cycles; the 127 beat has id_last=1 and id_count=3; first beat 2 cycles after input.
REQ-038 All-zero vector -> one beat with id_empty=1, id_last=1, id_out=0, id_count=0.
REQ-039 All 128 bits set -> ids 0..15; the id 15 beat has id_last=1, id_trunc=1 and id_count=16.
REQ-040 Two vectors {5} and {9} back-to-back with id_ready=1 -> id 5 (last), then id 9 (last) in the next cycle with no gap.
REQ-041 Push 6 vectors on consecutive cycles while id_ready=0 -> fifo_level reaches 4, overflow=1, and the 6th vector is never emitted.
REQ-042 rst pulsed during the second beat of {1,2,3} -> all outputs 0 the next cycle, and a new vector {7} then streams normally.
